// File: rtl/mole_spawner.sv
// Purpose: whackmole game control. Lights a pseudo-random mole for a bounded window and resolves it as hit or miss.
// Latency: enable rise to first lit LED is GAP_CYCLES+1 edges; a whack rising edge to the hit pulse and LED off is 1 cycle.
// Backpressure: none. The block free-runs, and SW edges outside the lit mole are dropped silently.
module mole_spawner #(
    parameter int          N_MOLES    = 10,
    parameter int          GAP_CYCLES = 25_000_000,
    parameter int          UP_CYCLES  = 50_000_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_MOLES-1:0] SW,
    output logic [N_MOLES-1:0] LEDR,
    output logic               hit,
    output logic               miss,
    output logic [7:0]         hit_count
);

    localparam int MAX_CYC = (GAP_CYCLES > UP_CYCLES) ? GAP_CYCLES : UP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int IW      = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;

    // A zero seed would lock the LFSR at zero forever, so it is replaced.
    localparam logic [15:0]        SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [CW-1:0]      GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]      UP_LOAD  = CW'(UP_CYCLES - 1);
    localparam logic [N_MOLES-1:0] ONE_HOT0 = N_MOLES'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_d;
    logic [N_MOLES-1:0] sw_q;
    logic [N_MOLES-1:0] rise;
    logic [IW-1:0]      idx_q;
    logic [IW-1:0]      idx_d;
    logic [N_MOLES-1:0] led_q;
    logic               hit_q;
    logic               miss_q;
    logic [7:0]         score_q;

    // Fibonacci LFSR step (taps 16,14,13,11), candidate mole index, and switch rising edges.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        idx_d  = IW'(lfsr_q % 16'(N_MOLES));
        rise   = SW & ~sw_q;
    end

    // Game FSM with registered LED, pulse and score outputs. enable low overrides every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= SEED;
            sw_q    <= SW;
            idx_q   <= '0;
            led_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            sw_q   <= SW;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                led_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= GAP;
                        cnt_q   <= GAP_LOAD;
                        led_q   <= '0;
                    end
                    GAP: begin
                        if (cnt_q == '0) begin
                            state_q <= UP;
                            cnt_q   <= UP_LOAD;
                            idx_q   <= idx_d;
                            led_q   <= ONE_HOT0 << idx_d;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    UP: begin
                        // A whack on the final lit cycle still counts, so hit is tested before timeout.
                        if (rise[idx_q]) begin
                            hit_q   <= 1'b1;
                            led_q   <= '0;
                            state_q <= GAP;
                            cnt_q   <= GAP_LOAD;
                            if (score_q != 8'hFF) begin
                                score_q <= score_q + 8'd1;
                            end
                        end else if (cnt_q == '0) begin
                            miss_q  <= 1'b1;
                            led_q   <= '0;
                            state_q <= GAP;
                            cnt_q   <= GAP_LOAD;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        led_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign LEDR      = led_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign hit_count = score_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Purpose: self-checking bench for mole_spawner using directed scenarios and a pulse scoreboard.
// Latency: inputs are driven and outputs are sampled on the falling edge, half a cycle after each active edge.
// Backpressure: not applicable; the monitor pops one expectation for each hit or miss pulse.
module tb_mole_spawner;

    localparam int N   = 10;
    localparam int GAP = 4;
    localparam int UPC = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] SW;
    logic [N-1:0] LEDR;
    logic         hit;
    logic         miss;
    logic [7:0]   hit_count;

    typedef struct {
        bit         is_hit;
        logic [7:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;
    logic [7:0]  exp_cnt;
    int          idx;

    mole_spawner #(
        .N_MOLES   (N),
        .GAP_CYCLES(GAP),
        .UP_CYCLES (UPC),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .SW       (SW),
        .LEDR     (LEDR),
        .hit      (hit),
        .miss     (miss),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left on every non-reset edge.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every hit or miss pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (hit === 1'b1 && miss === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL both_pulses: hit=1 miss=1 required at most one at %0t", $time);
        end
        if (hit === 1'b1 || miss === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: hit=%0b miss=%0b with empty scoreboard at %0t", hit, miss, $time);
            end else begin
                e = sb.pop_front();
                check("pulse_hit", {31'd0, hit}, {31'd0, e.is_hit});
                check("pulse_miss", {31'd0, miss}, {31'd0, !e.is_hit});
                check("pulse_count", {24'd0, hit_count}, {24'd0, e.cnt});
            end
        end
    end

    // Entered immediately after the edge that enters GAP. Confirms GAP_CYCLES dark cycles,
    // then returns one cycle into UP with the model's mole lit.
    task automatic gap_phase(output int id);
        id = 0;
        for (int i = 0; i < GAP; i++) begin
            check("gap_led", {22'd0, LEDR}, 32'd0);
            if (i == GAP - 1) id = int'(m_lfsr % 16'd10);
            @(negedge clk);
        end
        check("up_led", {22'd0, LEDR}, 32'd1 << id);
    endtask

    // Advance from UP cycle 1 to UP cycle k, confirming that the mole stays lit.
    task automatic up_to(input int k, input int id);
        for (int j = 1; j < k; j++) begin
            @(negedge clk);
            check("up_hold", {22'd0, LEDR}, 32'd1 << id);
        end
    endtask

    task automatic expect_pulse(input bit is_hit);
        exp_t e;
        if (is_hit && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e.is_hit = is_hit;
        e.cnt    = exp_cnt;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        SW      = '0;
        exp_cnt = 8'd0;
        idx     = 0;
        repeat (3) @(negedge clk);
        check("rst_led", {22'd0, LEDR}, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_miss", {31'd0, miss}, 32'd0);
        check("rst_cnt", {24'd0, hit_count}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_led", {22'd0, LEDR}, 32'd0);
        end

        // First mole: no whack, times out after UP_CYCLES lit cycles.
        enable = 1'b1;
        @(negedge clk);
        gap_phase(idx);
        expect_pulse(1'b0);
        up_to(UPC, idx);
        @(negedge clk);
        check("miss_led_off", {22'd0, LEDR}, 32'd0);

        // Whack on UP cycle 3.
        gap_phase(idx);
        up_to(3, idx);
        SW[idx] = 1'b1;
        expect_pulse(1'b1);
        @(negedge clk);
        check("hit_led_off", {22'd0, LEDR}, 32'd0);
        check("hit_cnt1", {24'd0, hit_count}, 32'd1);
        SW = '0;

        // Whack on the final UP cycle: the hit wins over the timeout.
        gap_phase(idx);
        up_to(UPC, idx);
        SW[idx] = 1'b1;
        expect_pulse(1'b1);
        @(negedge clk);
        check("last_hit_led_off", {22'd0, LEDR}, 32'd0);
        check("hit_cnt2", {24'd0, hit_count}, 32'd2);
        SW = '0;

        // Wrong switch raised: no effect, so the mole times out.
        gap_phase(idx);
        up_to(3, idx);
        SW[(idx + 1) % N] = 1'b1;
        expect_pulse(1'b0);
        up_to(UPC - 2, idx);
        @(negedge clk);
        check("wrong_led_off", {22'd0, LEDR}, 32'd0);
        SW = '0;

        // Switches held high from GAP through UP: no rising edge, so the mole times out.
        SW = '1;
        gap_phase(idx);
        expect_pulse(1'b0);
        up_to(UPC, idx);
        @(negedge clk);
        check("held_led_off", {22'd0, LEDR}, 32'd0);
        SW = '0;

        // Drop enable while a mole is lit.
        gap_phase(idx);
        up_to(2, idx);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dis_led", {22'd0, LEDR}, 32'd0);
            check("dis_cnt", {24'd0, hit_count}, 32'd2);
        end
        enable = 1'b1;
        @(negedge clk);
        gap_phase(idx);

        // Reset mid-UP.
        up_to(3, idx);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_led", {22'd0, LEDR}, 32'd0);
        check("midrst_hit", {31'd0, hit}, 32'd0);
        check("midrst_miss", {31'd0, miss}, 32'd0);
        check("midrst_cnt", {24'd0, hit_count}, 32'd0);
        exp_cnt = 8'd0;
        reset   = 1'b0;
        @(negedge clk);

        // 300 consecutive hits: the score saturates at 255 while hit pulses continue.
        for (int n = 0; n < 300; n++) begin
            gap_phase(idx);
            SW[idx] = 1'b1;
            expect_pulse(1'b1);
            @(negedge clk);
            SW = '0;
        end
        check("sat_cnt", {24'd0, hit_count}, 32'd255);

        @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
